// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-port ALU arbiter: ALU op encodings, op width and FSM states.
package alu_arbiter_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SLL = 3'd5,
        OP_SRL = 3'd6,
        OP_SRA = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_arb_pick.sv
// Grant selection for two requesters: on a tie the requester not granted last wins.
module alu_arb_pick
    import alu_arbiter_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = valid;
        if (valid[0] && valid[1]) begin
            grant = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU, sequenced IDLE -> EXEC -> RESP.
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_data,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_data,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_c,
    output logic              busy
);

    state_e            state_q, state_d;
    logic [OP_W-1:0]   op_q;
    logic [DATA_W-1:0] a_q, b_q, result_q;
    logic              owner_q;
    logic              last_q;
    logic              accept;
    logic              rsp_done;
    logic [1:0]        grant;

    alu_arb_pick u_pick (
        .valid ({req1_valid, req0_valid}),
        .last  (last_q),
        .grant (grant)
    );

`ifdef ALU_ARB_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (accept) begin
            last_q <= grant[1];
        end
    end
`else
    // Pinning the pointer at requester 1 makes the picker fixed-priority for requester 0.
    assign last_q = 1'b1;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: each combinational output is given a default first, so no latch can be inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)   state_d = ST_EXEC;
            ST_EXEC:               state_d = ST_RESP;
            ST_RESP: if (rsp_done) state_d = ST_IDLE;
            default:               state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        accept     = 1'b0;
        rsp_done   = 1'b0;
        busy       = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                req0_ready = grant[0];
                req1_ready = grant[1];
                accept     = |grant;
            end
            ST_RESP: begin
                rsp0_valid = !owner_q;
                rsp1_valid = owner_q;
                rsp_done   = owner_q ? rsp1_ready : rsp0_ready;
            end
            default: ;
        endcase
    end

    // NOTE: these registers are reset because they drive the ALU and response ports directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            owner_q  <= 1'b0;
            result_q <= '0;
        end else begin
            if (accept) begin
                owner_q <= grant[1];
                op_q    <= grant[1] ? req1_op : req0_op;
                a_q     <= grant[1] ? req1_a  : req0_a;
                b_q     <= grant[1] ? req1_b  : req0_b;
            end
            if (state_q == ST_EXEC) begin
                result_q <= alu_c;
            end
        end
    end

    assign alu_op    = op_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign rsp0_data = result_q;
    assign rsp1_data = result_q;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports reqN_valid input 1, reqN_ready output 1, reqN_op input 3, reqN_a input DATA_W, reqN_b input DATA_W, for N = 0, 1.
REQ-005 SHALL have ports rspN_valid output 1, rspN_ready input 1, rspN_data output DATA_W, for N = 0, 1.
REQ-006 SHALL have ports alu_op output 3, alu_a output DATA_W, alu_b output DATA_W, driving the shared combinational ALU.
REQ-007 SHALL have port alu_c  input  DATA_W  ALU result.
REQ-008 SHALL have port busy  output  1  high in any state except IDLE.

Function
REQ-009 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE.
REQ-010 IDLE: reqN_ready high only for the granted requester, and only in IDLE; a handshake is valid&&ready.
REQ-011 IDLE: on handshake, latch op/a/b and owner id, go to EXEC next cycle.
REQ-012 EXEC: alu_op/alu_a/alu_b driven from latched registers; alu_c captured into result register at end of cycle; go to RESP.
REQ-013 alu_op/alu_a/alu_b SHALL always reflect latched registers, stable outside EXEC.
REQ-014 RESP: rsp<owner>_valid high, rsp<owner>_data = result register; the other rspN_valid low.
REQ-015 RESP: on rsp<owner>_ready, go to IDLE; rspN_valid and data held until then.
REQ-016 Latency: handshake cycle T -> rspN_valid at T+2; max throughput one op per 3 cycles.
REQ-017 No new request accepted before the response handshake completes.
REQ-018 Op codes are passed to the ALU unmodified; no op legality check.
REQ-019 Result is alu_c truncated/held at DATA_W; no overflow flagging.
REQ-020 A requester dropping valid before ready SHALL not be granted; no latching occurs.

Reset
REQ-021 On rst: state IDLE, busy 0, all rspN_valid 0, rspN_data 0, alu_op/alu_a/alu_b 0, owner 0, last-grant pointer 1.
REQ-022 Reset mid-EXEC or mid-RESP SHALL discard the operation; no response issued after reset.

Configuration
REQ-023 ALU_ARB_RR_EN defined: round-robin; on simultaneous valid, grant the requester not granted last; pointer updates on each grant.
REQ-024 ALU_ARB_RR_EN undefined: fixed priority, requester 0 always wins; pointer logic absent.

Structure
REQ-025 Shared package SHALL hold the 3-bit ALU op encodings (ADD, SUB, AND, OR, XOR, SLL, SRL, SRA), the op width constant and the FSM state enum.
REQ-026 Grant selection SHALL be a sub-module alu_arb_pick (inputs valid[1:0], last pointer; output one-hot grant).

Verification
REQ-027 Req0 ADD a=5 b=7, rsp0_ready=1 -> rsp0_valid at T+2, rsp0_data=12, rsp1_valid stays 0.
REQ-028 Both valid in same IDLE cycle, RR_EN defined -> req0 granted first, req1 second; RR_EN undefined, req0 held valid -> req1 never granted.
REQ-029 Req1 SRA a=0x80000000 b=4, rsp1_ready low 5 cycles -> rsp1_data=0xF8000000 held stable, busy=1, req0_ready=0 throughout.
REQ-030 rst pulsed during EXEC of SUB 3-5 -> next cycle busy=0, rsp0_valid=0, no response ever appears.
REQ-031 Back-to-back req0 SUB 10-3 then XOR 0xFF^0x0F -> responses 7 then 0xF0, handshakes 3 cycles apart.
